// File: rtl/bitmask_scheduler_pkg.sv
// bitmask_scheduler_pkg: shared widths and state encoding for the bitmask scheduler
package bitmask_scheduler_pkg;
    localparam int MASK_W = 7;
    localparam int IDX_W = 3;
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_e;
endpackage

// File: rtl/bitmask_scheduler_if.sv
// bitmask_scheduler_if: operand-in / beat-out valid-ready bundle plus flush
interface bitmask_scheduler_if #(parameter int TAG_W = 8);
    import bitmask_scheduler_pkg::*;
    logic flush;
    logic in_valid;
    logic in_ready;
    logic [MASK_W-1:0] in_mask;
    logic [TAG_W-1:0] in_tag;
    logic out_valid;
    logic out_ready;
    logic [IDX_W-1:0] out_idx;
    logic out_last;
    logic out_zero;
    logic [TAG_W-1:0] out_tag;
    logic [IDX_W-1:0] out_seq;
    modport master (
        output flush, in_valid, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_zero, out_tag, out_seq
    );
    modport slave (
        input  flush, in_valid, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_zero, out_tag, out_seq
    );
endinterface

// File: rtl/bitmask_scheduler_pencoder_7to3.sv
// pencoder_7to3: lowest-set-bit priority encoder, idx 0 when no bit is set
module pencoder_7to3 (
    input  logic [6:0] req,
    output logic [2:0] idx,
    output logic       val
);
    always_comb begin
        val = |req;
        idx = req[0] ? 3'd0 :
              req[1] ? 3'd1 :
              req[2] ? 3'd2 :
              req[3] ? 3'd3 :
              req[4] ? 3'd4 :
              req[5] ? 3'd5 :
              req[6] ? 3'd6 : 3'd0;
    end
endmodule

// File: rtl/bitmask_scheduler.sv
// bitmask_scheduler: walks a 7-bit mask one set bit per beat, LSB first, one marked beat for an empty mask
module bitmask_scheduler #(parameter int TAG_W = 8) (
    input logic clk,
    input logic rst_n,
    bitmask_scheduler_if.slave bus
);
    import bitmask_scheduler_pkg::*;
    sched_state_e state;
    logic [MASK_W-1:0] rem;
    logic [MASK_W-1:0] rem_lo;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] seq_q;
    logic [IDX_W-1:0] penc_idx;
    logic penc_val;
    logic run;
    logic last;
    logic load;
    pencoder_7to3 u_penc (.req(rem), .idx(penc_idx), .val(penc_val));
    // rem_lo drops the lowest set bit, which is exactly the bit being emitted
    always_comb begin
        run = state == S_RUN;
        rem_lo = rem & (rem - MASK_W'(1));
        last = rem_lo == '0;
        bus.in_ready = !bus.flush && (!run || (bus.out_ready && last));
        load = bus.in_valid && bus.in_ready;
        bus.out_valid = run;
        bus.out_idx = penc_idx;
        bus.out_last = run && last;
        bus.out_zero = run && rem == '0;
        bus.out_tag = tag_q;
        bus.out_seq = seq_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            rem <= '0;
            tag_q <= '0;
            seq_q <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            rem <= '0;
        end else if (load) begin
            state <= S_RUN;
            rem <= bus.in_mask;
            tag_q <= bus.in_tag;
            seq_q <= '0;
        end else if (run && bus.out_ready) begin
            state <= last ? S_IDLE : S_RUN;
            rem <= rem_lo;
            seq_q <= last ? seq_q : seq_q + 1'b1;
        end
    end
    assert property (@(posedge clk) disable iff (!rst_n) run |-> penc_val == !bus.out_zero);
endmodule

// File: tb/tb_bitmask_scheduler.sv
// tb_bitmask_scheduler: directed scenarios plus randomized run against a beat-list model
module tb_bitmask_scheduler;
    typedef struct packed {
        logic v; logic [2:0] idx; logic last; logic zero; logic [2:0] seq; logic [7:0] tag; logic rdy;
    } obs_t;
    typedef struct packed {
        logic iv; logic [6:0] m; logic [7:0] t; logic ordy; logic fl;
    } stim_t;
    typedef struct packed {
        logic [2:0] idx; logic last; logic zero; logic [2:0] seq; logic [7:0] tag;
    } beat_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_fail = 0;
    bitmask_scheduler_if #(.TAG_W(8)) bus ();
    bitmask_scheduler #(.TAG_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    function automatic obs_t sample();
        return '{bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero, bus.out_seq, bus.out_tag, bus.in_ready};
    endfunction
    function automatic obs_t mk(int v, int idx, int last, int zero, int seq, int tag, int rdy);
        return '{v[0], idx[2:0], last[0], zero[0], seq[2:0], tag[7:0], rdy[0]};
    endfunction
    function automatic obs_t idle(int rdy);
        return mk(0, 0, 0, 0, 0, 0, rdy);
    endfunction
    function automatic stim_t st(int iv, int m, int t, int ordy, int fl);
        return '{iv[0], m[6:0], t[7:0], ordy[0], fl[0]};
    endfunction
    function automatic string fmt(obs_t o);
        return $sformatf("v=%0b idx=%0d last=%0b zero=%0b seq=%0d tag=%02h rdy=%0b",
                         o.v, o.idx, o.last, o.zero, o.seq, o.tag, o.rdy);
    endfunction
    task automatic cyc(input stim_t s);
        @(negedge clk);
        bus.in_valid = s.iv;
        bus.in_mask = s.m;
        bus.in_tag = s.t;
        bus.out_ready = s.ordy;
        bus.flush = s.fl;
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        cyc(st(0, 0, 0, 1, 0));
        o = sample();
        n_cmp++;
        if (o !== idle(1)) begin
            n_fail++;
            $display("FAIL reset: got %s want %s", fmt(o), fmt(idle(1)));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 7'b1010010, 8'h3C, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0)};
        e = '{idle(1), mk(1, 1, 0, 0, 0, 8'h3C, 0), mk(1, 4, 0, 0, 1, 8'h3C, 0), mk(1, 6, 1, 0, 2, 8'h3C, 1), idle(1)};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL single[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
    endtask

    task automatic test_zero();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 0, 8'h11, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0)};
        e = '{idle(1), mk(1, 0, 1, 1, 0, 8'h11, 1), idle(1)};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL zero[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 7'b0000001, 8'hA1, 1, 0), st(1, 7'b1111111, 8'hB2, 1, 0)};
        e = '{idle(1), mk(1, 0, 1, 0, 0, 8'hA1, 1)};
        for (int k = 0; k < 7; k++) begin
            s.push_back(st(0, 0, 0, 1, 0));
            e.push_back(mk(1, k, k == 6, 0, k, 8'hB2, k == 6));
        end
        s.push_back(st(0, 0, 0, 1, 0));
        e.push_back(idle(1));
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
    endtask

    task automatic test_backpressure();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 7'b0001100, 8'h5A, 1, 0), st(1, 7'b1111111, 8'hFF, 0, 0), st(1, 7'b1111111, 8'hFF, 0, 0),
              st(1, 7'b1111111, 8'hFF, 0, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0)};
        e = '{idle(1), mk(1, 2, 0, 0, 0, 8'h5A, 0), mk(1, 2, 0, 0, 0, 8'h5A, 0), mk(1, 2, 0, 0, 0, 8'h5A, 0),
              mk(1, 2, 0, 0, 0, 8'h5A, 0), mk(1, 3, 1, 0, 1, 8'h5A, 1), idle(1)};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
    endtask

    task automatic test_flush();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 7'b1110000, 8'h77, 1, 0), st(0, 0, 0, 1, 0), st(1, 7'b0100000, 8'hEE, 0, 1),
              st(1, 7'b0100000, 8'h99, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0)};
        e = '{idle(1), mk(1, 4, 0, 0, 0, 8'h77, 0), mk(1, 5, 0, 0, 1, 8'h77, 0),
              idle(1), mk(1, 5, 1, 0, 0, 8'h99, 1), idle(1)};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL flush[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
    endtask

    task automatic test_async_reset();
        stim_t s[$];
        obs_t e[$];
        obs_t o;
        s = '{st(1, 7'b1111111, 8'hC3, 1, 0), st(0, 0, 0, 1, 0), st(0, 0, 0, 1, 0)};
        e = '{idle(1), mk(1, 0, 0, 0, 0, 8'hC3, 0), mk(1, 1, 0, 0, 1, 8'hC3, 0)};
        for (int i = 0; i < s.size(); i++) begin
            cyc(s[i]);
            o = sample();
            n_cmp++;
            if (e[i].v ? (o !== e[i]) : ({o.v, o.rdy} !== {e[i].v, e[i].rdy})) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got %s want %s", i, fmt(o), fmt(e[i]));
            end
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            o = sample();
            n_cmp++;
            if (o !== idle(1)) begin
                n_fail++;
                $display("FAIL async_reset_hold[%0d]: got %s want %s", i, fmt(o), fmt(idle(1)));
            end
            if (i == 1) rst_n = 1'b1;
            cyc(st(0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_random();
        beat_t q[$];
        for (int c = 0; c < 600; c++) begin
            stim_t s;
            obs_t o;
            obs_t e;
            logic r;
            int n;
            s = st($urandom_range(0, 2) != 0, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 127),
                   $urandom_range(0, 255), $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
            cyc(s);
            r = !s.fl && (q.size() == 0 || (s.ordy && q[0].last));
            e = (q.size() == 0) ? idle(r) : mk(1, q[0].idx, q[0].last, q[0].zero, q[0].seq, q[0].tag, r);
            o = sample();
            n_cmp++;
            if (e.v ? (o !== e) : ({o.v, o.rdy} !== {e.v, e.rdy})) begin
                n_fail++;
                $display("FAIL random[%0d]: got %s want %s", c, fmt(o), fmt(e));
            end
            if (q.size() != 0 && s.ordy) void'(q.pop_front());
            if (s.fl) q.delete();
            else if (s.iv && r) begin
                n = 0;
                for (int i = 0; i < 7; i++)
                    if (s.m[i]) begin
                        q.push_back('{i[2:0], 1'b0, 1'b0, n[2:0], s.t});
                        n++;
                    end
                if (n == 0) q.push_back('{3'd0, 1'b1, 1'b1, 3'd0, s.t});
                else q[q.size() - 1].last = 1'b1;
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_mask = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_single();
        test_zero();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bitmask_scheduler.md
# bitmask_scheduler

Sequencer that walks a 7-bit essential-bit mask one set bit per cycle, LSB first, and emits each bit index as one beat of a valid/ready stream. It sits between the operand fetch stage and the bit-serial shift-add lane, reusing the 7-to-3 priority encoder to pick the next index. An all-zero mask still produces exactly one marked beat, so downstream accumulators see one beat group per operand.

## Interface
- `MASK_W`, default 7: mask width. Fixed at 7 for this revision.
- `IDX_W`, default 3: index width, equal to clog2(`MASK_W`).
- `TAG_W`, default 8: width of the opaque operand tag carried through.
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `flush`, in, 1: synchronous abort of the current operand.
- `in_valid`, in, 1: operand offered.
- `in_ready`, out, 1: operand accepted this cycle when high together with `in_valid`.
- `in_mask`, in, `MASK_W`: essential-bit mask.
- `in_tag`, in, `TAG_W`: operand tag.
- `out_valid`, out, 1: beat valid.
- `out_ready`, in, 1: downstream accepts the beat.
- `out_idx`, out, `IDX_W`: bit position of the current beat.
- `out_last`, out, 1: final beat of the operand.
- `out_zero`, out, 1: beat stands for an all-zero mask; `out_idx` is 0.
- `out_tag`, out, `TAG_W`: tag of the operand being walked.
- `out_seq`, out, `IDX_W`: beat ordinal within the operand, starting at 0.

## Operation
- Registers: `state`, `rem` (remaining mask), `tag_q`, `seq_q`.
- There are two states, IDLE and RUN.
- **IDLE:**
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid`: `rem` ← `in_mask`, `tag_q` ← `in_tag`, `seq_q` ← 0, then go to RUN.
- **RUN:**
  - `out_valid` = 1.
  - `out_idx` = priority_encode(`rem`), where the lowest set bit wins. It is 0 when `rem` is 0.
  - `out_zero` = (`rem` == 0).
  - `out_last` = (`rem` has at most one set bit).
  - `out_tag` = `tag_q` and `out_seq` = `seq_q`.
- **Beat accepted (`out_valid` and `out_ready`), not last:**
  - Clear bit `out_idx` in `rem`.
  - Increment `seq_q`. It never wraps: at most 7 beats.
- **Beat accepted and `out_last`:**
  - `in_ready` = 1 in that same cycle.
  - If `in_valid`, load the new operand and stay in RUN. This gives zero-bubble back-to-back operation.
  - Otherwise return to IDLE.
- `in_ready` = IDLE or (RUN and `out_ready` and `out_last`).
- In RUN without acceptance, all outputs hold stable (AXI-style rule). `out_valid` never drops until its beat is accepted.
- **`flush`:**
  - Next state is IDLE and `rem` ← 0.
  - `in_ready` is forced to 0 during the flush cycle.
  - A beat handshaking in the flush cycle counts as delivered, but no further beats of that operand are emitted.
  - Flush overrides load.
- The number of beats per operand is max(1, popcount(`in_mask`)).
- `in_mask` changing while `in_ready` = 0 has no effect.

## Timing
- **Reset values (async, on `rst_n` low):**
  - `state` is IDLE, and `rem`, `tag_q`, `seq_q` are 0.
  - Outputs: `out_valid` 0, `out_idx` 0, `out_last` 0, `out_zero` 0, `out_tag` 0, `out_seq` 0, `in_ready` 1.
- Reset mid-operand discards it. There is no beat after reset deassertion until a new accept.
- **Latency:** an operand accepted at edge t shows its first beat valid in cycle t+1.
- **Throughput:** one beat per cycle when `out_ready` stays high. Operands of k beats occupy exactly k cycles back-to-back.
- There is no combinational path from `in_*` to `out_*`. There is one from `out_ready` to `in_ready`, and it is permitted.
- `out_idx`, `out_last`, and `out_zero` are decoded from registered `rem` only.

## Structure
- The shared package holds:
  - the `MASK_W` and `IDX_W` constants;
  - the state enum `sched_state_e` with values `S_IDLE` and `S_RUN`.
- There is one sub-module: `pencoder_7to3`, instanced on `rem`.
  - Its `val` output is unused except as an assertion cross-check against `!out_zero`.
- Popcount-≤1 detection is `(rem & (rem - 1)) == 0`, computed locally.

## Test plan
- **Single operand, `out_ready` = 1:** `in_mask` = 7'b1010010 with tag 0x3C. Expect three beats:
  - `idx` 1, `seq` 0, `last` 0;
  - `idx` 4, `seq` 1, `last` 0;
  - `idx` 6, `seq` 2, `last` 1.
  - All three carry tag 0x3C. Then `in_ready` = 1 in the last cycle.
- **Zero mask:** `in_mask` = 0. Expect exactly one beat with `out_zero` 1, `out_last` 1, `idx` 0, `seq` 0.
- **Back-to-back:** masks 7'b0000001 then 7'b1111111 offered continuously. Expect beats idx 0(last), 0, 1, 2, 3, 4, 5, 6(last) in 8 consecutive cycles with no bubble; `seq` runs 0..6 on the second operand.
- **Backpressure:** mask 7'b0001100 with `out_ready` held low 3 cycles on the first beat. `idx` 2 stays stable with `out_valid` 1, `in_ready` stays 0; then idx 2 and idx 3(last) follow.
- **Flush:** assert `flush` after the first beat of mask 7'b1110000 is accepted. Next cycle `out_valid` = 0 and IDLE. The next operand, 7'b0100000, yields a single beat with idx 5, `seq` 0.
- **Async reset mid-operand:** drop `rst_n` during beat 2 of 7'b1111111. All outputs go to their reset values immediately. After release, no beat appears until a new `in_valid`.
